// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder family.
// The optional DECODER_SCAN_BLANK_EN build adds a BLANK state between scan steps.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2,
    BLANK  = 2'd3
  } state_t;

  // Widest select supported by onehot(); users narrow the result with N_OUT'(...).
  localparam int MAX_N_BITS = 8;
  localparam int MAX_N_OUT  = 2 ** MAX_N_BITS;

  // Output count is always 2**N_BITS (not N_BITS**2); each block declares
  // localparam int N_OUT = 2 ** N_BITS using this default as the reference.
  localparam int DEFAULT_N_BITS = 3;
  localparam int DEFAULT_N_OUT  = 2 ** DEFAULT_N_BITS;

  function automatic logic [MAX_N_OUT-1:0] onehot(input logic [MAX_N_BITS-1:0] sel);
    onehot = MAX_N_OUT'(1) << sel;
  endfunction

endpackage

// File: rtl/decoder_scan_n_dwell_counter.sv
// Terminal-count dwell timer; done is high on the last cycle of each dwell period.
// Reusable by other multiplexing blocks; clr has priority over en.
module dwell_counter #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] count;

  assign done = en && (count == TERMINAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || done) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder with direct and autonomous scan modes.
// Define DECODER_SCAN_BLANK_EN to insert one all-zero BLANK cycle before every scan step.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int N_BITS       = 3,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 mode,
  input  logic [N_BITS-1:0]    a,
  input  logic [N_BITS-1:0]    last,
  output logic [2**N_BITS-1:0] out,
  output logic [N_BITS-1:0]    idx,
  output logic                 wrap
);

  localparam int N_OUT = 2 ** N_BITS;

  state_t            state;
  logic [N_BITS-1:0] last_reg;
  logic [N_BITS-1:0] idx_adv;
  logic              at_last;
  logic              dwell_en;
  logic              dwell_clr;
  logic              dwell_done;

  // The timer only runs while a scan is actually continuing this cycle, so
  // disable, mode change and scan entry all leave it cleared for the next dwell.
  assign dwell_en  = ena && mode && (state == SCAN);
  assign dwell_clr = !dwell_en;
  assign at_last   = (idx == last_reg);
  assign idx_adv   = at_last ? '0 : idx + N_BITS'(1);

  dwell_counter #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (dwell_clr),
    .en   (dwell_en),
    .done (dwell_done)
  );

  // Priority: reset, then ena=0, then mode, then the scan advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out      <= '0;
      idx      <= '0;
      wrap     <= 1'b0;
      last_reg <= '0;
    end else if (!ena) begin
      state <= IDLE;
      out   <= '0;
      wrap  <= 1'b0;
    end else if (!mode) begin
      state <= DIRECT;
      out   <= N_OUT'(onehot(MAX_N_BITS'(a)));
      idx   <= a;
      wrap  <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (dwell_done) begin
            idx  <= idx_adv;
            wrap <= at_last;
            if (at_last) begin
              last_reg <= last;
            end
`ifdef DECODER_SCAN_BLANK_EN
            state <= BLANK;
            out   <= '0;
`else
            out   <= N_OUT'(onehot(MAX_N_BITS'(idx_adv)));
`endif
          end else begin
            wrap <= 1'b0;
          end
        end
`ifdef DECODER_SCAN_BLANK_EN
        BLANK: begin
          state <= SCAN;
          out   <= N_OUT'(onehot(MAX_N_BITS'(idx)));
          wrap  <= 1'b0;
        end
`endif
        default: begin
          state    <= SCAN;
          idx      <= '0;
          out      <= N_OUT'(1);
          wrap     <= 1'b0;
          last_reg <= last;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench for decoder_scan_n: two instances (dwell 4 and dwell 1) share stimulus.
// A time-based sweep model predicts out/idx/wrap; honours DECODER_SCAN_BLANK_EN when defined.
module tb_decoder_scan_n;

`ifdef DECODER_SCAN_BLANK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif

  localparam int M_OFF = 0;
  localparam int M_DIR = 1;
  localparam int M_SCN = 2;

  typedef struct packed {
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;
  typedef exp_t [1:0] pair_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       mode;
  logic [2:0] a;
  logic [2:0] last;
  logic [7:0] out4, out1;
  logic [2:0] idx4, idx1;
  logic       wrap4, wrap1;

  pair_t sb[$];
  int    compared   = 0;
  int    mismatched = 0;

  int m_state[2];
  int m_s[2];
  int m_last[2];
  int m_pending[2];
  int m_idx[2];

  decoder_scan_n #(.N_BITS(3), .DWELL_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .a(a), .last(last),
    .out(out4), .idx(idx4), .wrap(wrap4)
  );

  decoder_scan_n #(.N_BITS(3), .DWELL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .a(a), .last(last),
    .out(out1), .idx(idx1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: in scan, position follows from cycles elapsed in the current sweep.
  function automatic exp_t modelStep(int i, logic r_n, logic en, logic md, int av, int lv);
    exp_t e;
    int dw, step, period, slot, r, nxt;
    dw   = (i == 0) ? 4 : 1;
    step = dw + BL;
    e    = '0;
    if (!r_n) begin
      m_state[i] = M_OFF;
      m_idx[i]   = 0;
    end else if (!en) begin
      m_state[i] = M_OFF;
      e.idx      = 3'(m_idx[i]);
    end else if (!md) begin
      m_state[i] = M_DIR;
      m_idx[i]   = av;
      e.out      = 8'(1) << av;
      e.idx      = 3'(av);
    end else if (m_state[i] != M_SCN) begin
      m_state[i] = M_SCN;
      m_s[i]     = 0;
      m_last[i]  = lv;
      m_idx[i]   = 0;
      e.out      = 8'd1;
    end else begin
      m_s[i]++;
      period = (m_last[i] + 1) * step;
      if (m_s[i] == period) begin
        m_s[i]    = 0;
        m_last[i] = (BL != 0) ? m_pending[i] : lv;
      end
      period = (m_last[i] + 1) * step;
      if (BL != 0 && m_s[i] == period - 1) m_pending[i] = lv;
      slot = m_s[i] / step;
      r    = m_s[i] % step;
      if (r < dw) begin
        e.out  = 8'(1) << slot;
        e.idx  = 3'(slot);
        e.wrap = (BL == 0) && (m_s[i] == 0);
      end else begin
        nxt    = (slot == m_last[i]) ? 0 : slot + 1;
        e.idx  = 3'(nxt);
        e.wrap = (slot == m_last[i]);
      end
      m_idx[i] = int'(e.idx);
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic r_n, input logic en, input logic md,
                               input int av, input int lv);
    pair_t p;
    @(negedge clk);
    #1;
    rst_n = r_n;
    ena   = en;
    mode  = md;
    a     = 3'(av);
    last  = 3'(lv);
    for (int i = 0; i < 2; i++) p[i] = modelStep(i, r_n, en, md, av, lv);
    sb.push_back(p);
  endtask

  task automatic checkField(input string name, input int i, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0h, expected %0h", name, i, $time, act, req);
    end
  endtask

  task automatic checkOutput(input pair_t p);
    logic [7:0] o;
    logic [2:0] x;
    logic       w;
    for (int i = 0; i < 2; i++) begin
      o = (i == 0) ? out4 : out1;
      x = (i == 0) ? idx4 : idx1;
      w = (i == 0) ? wrap4 : wrap1;
      checkField("out", i, int'(o), int'(p[i].out));
      checkField("idx", i, int'(x), int'(p[i].idx));
      checkField("wrap", i, int'(w), int'(p[i].wrap));
      compared++;
      if ($countones(o) > 1) begin
        mismatched++;
        $display("[TB] FAIL onehot dut%0d at %0t: got %b, expected at most one bit", i, $time, o);
      end
    end
  endtask

  // Monitor samples on the falling edge, before the next stimulus is driven.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    mode  = 1'b0;
    a     = '0;
    last  = '0;
    for (int i = 0; i < 2; i++) begin
      m_state[i] = M_OFF; m_s[i] = 0; m_last[i] = 0; m_pending[i] = 0; m_idx[i] = 0;
    end

    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    for (int v = 0; v < 8; v++) applyStimulus(1, 1, 0, v, 0);

    repeat (70) applyStimulus(1, 1, 1, 0, 7);
    repeat (2) applyStimulus(0, 1, 1, 0, 7);
    repeat (6) applyStimulus(1, 1, 1, 0, 7);

    applyStimulus(1, 0, 1, 0, 2);
    repeat (5) applyStimulus(1, 1, 1, 0, 2);
    repeat (40) applyStimulus(1, 1, 1, 0, 5);

    applyStimulus(1, 0, 1, 0, 0);
    repeat (20) applyStimulus(1, 1, 1, 0, 0);

    applyStimulus(1, 0, 1, 0, 7);
    repeat (10) applyStimulus(1, 1, 1, 0, 7);
    applyStimulus(1, 0, 1, 0, 7);
    repeat (10) applyStimulus(1, 1, 1, 0, 7);

    repeat (9) applyStimulus(1, 1, 1, 6, 7);
    repeat (3) applyStimulus(1, 1, 0, 6, 7);

    begin
      logic r_md, r_en, r_rn;
      int   r_last;
      r_md   = 1'b1;
      r_last = 3;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 24) == 0) r_md = ~r_md;
        if ($urandom_range(0, 9) == 0) r_last = int'($urandom_range(0, 7));
        r_en = ($urandom_range(0, 19) != 0);
        r_rn = ($urandom_range(0, 149) != 0);
        applyStimulus(r_rn, r_en, r_md, int'($urandom_range(0, 7)), r_last);
      end
    end

    repeat (3) @(posedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
